// File: rtl/procesador_pkg.sv
// Shared definitions for the 12-bit accumulator processor and its program loader.
package procesador_pkg;

    localparam int ANCHO_DATO  = 12;
    localparam int ANCHO_DIR   = 6;
    localparam int PROFUNDIDAD = 64;

    localparam logic [3:0] LOAD  = 4'd1;
    localparam logic [3:0] STORE = 4'd2;
    localparam logic [3:0] ADD   = 4'd3;
    localparam logic [3:0] SUB   = 4'd4;
    localparam logic [3:0] MUL   = 4'd5;
    localparam logic [3:0] DIV   = 4'd6;
    localparam logic [3:0] AND   = 4'd7;
    localparam logic [3:0] OR    = 4'd8;
    localparam logic [3:0] XOR   = 4'd9;
    localparam logic [3:0] NOT   = 4'd10;
    localparam logic [3:0] JMP   = 4'd11;
    localparam logic [3:0] INC   = 4'd12;
    localparam logic [3:0] DEC   = 4'd13;
    localparam logic [3:0] SHL   = 4'd14;
    localparam logic [3:0] SHR   = 4'd15;

    typedef enum logic [1:0] {
        LIMPIAR,
        ESPERA,
        ESCRIBIR,
        EJECUTAR
    } estado_t;

endpackage

// File: rtl/cargador_programa_contador_retencion.sv
// Hold counter: while activo, pulses fin on the last of every CICLOS consecutive cycles.
module contador_retencion #(
    parameter int CICLOS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic activo,
    output logic fin
);

    localparam int W = (CICLOS > 1) ? $clog2(CICLOS) : 1;

    logic [W-1:0] cnt;

    assign fin = activo && (cnt == W'(CICLOS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!activo || fin) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cargador_programa.sv
// Program loader: clears processor memory, writes {address, word} records, then releases the processor.
module cargador_programa #(
    parameter int ANCHO_DATO       = procesador_pkg::ANCHO_DATO,
    parameter int ANCHO_DIR        = procesador_pkg::ANCHO_DIR,
    parameter int PROFUNDIDAD      = procesador_pkg::PROFUNDIDAD,
    parameter int CICLOS_ESCRITURA = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valido,
    output logic                  listo,
    input  logic [ANCHO_DIR-1:0]  dir_in,
    input  logic [ANCHO_DATO-1:0] dato_in,
    input  logic                  ultimo,
    input  logic                  recargar,
    output logic                  wr,
    output logic [ANCHO_DIR-1:0]  direccion,
    output logic [ANCHO_DATO-1:0] datoEntrante,
    output logic                  ejecutando,
    output logic                  error_dir,
    output logic [7:0]            palabras_cargadas
);

    import procesador_pkg::*;

    localparam logic [ANCHO_DIR-1:0] ULT_DIR = ANCHO_DIR'(PROFUNDIDAD - 1);

    estado_t               estado_q, estado_d;
    logic [ANCHO_DIR-1:0]  dir_q, dir_d;
    logic [ANCHO_DATO-1:0] dato_q, dato_d;
    logic                  ult_q, ult_d;
    logic                  err_q, err_d;
    logic [7:0]            pal_q, pal_d;
    logic                  activo, fin, acepta, fuera;

    assign activo = (estado_q == LIMPIAR) || (estado_q == ESCRIBIR);
    assign acepta = valido && listo;
    assign fuera  = 32'(dir_in) >= PROFUNDIDAD;

    contador_retencion #(
        .CICLOS(CICLOS_ESCRITURA)
    ) u_retencion (
        .clk   (clk),
        .reset (reset),
        .activo(activo),
        .fin   (fin)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= LIMPIAR;
            dir_q    <= '0;
            dato_q   <= '0;
            ult_q    <= 1'b0;
            err_q    <= 1'b0;
            pal_q    <= '0;
        end else begin
            estado_q <= estado_d;
            dir_q    <= dir_d;
            dato_q   <= dato_d;
            ult_q    <= ult_d;
            err_q    <= err_d;
            pal_q    <= pal_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        dir_d    = dir_q;
        dato_d   = dato_q;
        ult_d    = ult_q;
        err_d    = err_q;
        pal_d    = pal_q;
        case (estado_q)
            LIMPIAR: begin
                if (fin) begin
                    if (dir_q == ULT_DIR) estado_d = ESPERA;
                    else                  dir_d    = dir_q + 1'b1;
                end
            end
            ESPERA: begin
                if (acepta) begin
                    // Out-of-range records never reach the memory port; ultimo still ends the load.
                    if (fuera) begin
                        err_d = 1'b1;
                        if (ultimo) estado_d = EJECUTAR;
                    end else begin
                        dir_d    = dir_in;
                        dato_d   = dato_in;
                        ult_d    = ultimo;
                        estado_d = ESCRIBIR;
                        if (pal_q != 8'hFF) pal_d = pal_q + 8'd1;
                    end
                end
            end
            ESCRIBIR: begin
                if (fin) estado_d = ult_q ? EJECUTAR : ESPERA;
            end
            EJECUTAR: begin
                if (recargar) begin
                    estado_d = LIMPIAR;
                    dir_d    = '0;
                    dato_d   = '0;
                    ult_d    = 1'b0;
                    err_d    = 1'b0;
                    pal_d    = '0;
                end
            end
            default: estado_d = LIMPIAR;
        endcase
    end

    // Port values are decoded from the state register so reset reaches them without a clock.
    assign listo             = (estado_q == ESPERA);
    assign ejecutando        = (estado_q == EJECUTAR);
    assign wr                = (estado_q != EJECUTAR);
    assign direccion         = (estado_q == EJECUTAR) ? '0 : dir_q;
    assign datoEntrante      = ((estado_q == ESPERA) || (estado_q == ESCRIBIR)) ? dato_q : '0;
    assign error_dir         = err_q;
    assign palabras_cargadas = pal_q;

endmodule

// File: tb/tb_cargador_programa.sv
// Directed bench for cargador_programa with a processor-memory model fed by wr/direccion/datoEntrante.
module tb_cargador_programa;

    logic        clk = 1'b0;
    logic        reset, valido, ultimo, recargar;
    logic [5:0]  dir_in;
    logic [11:0] dato_in;
    logic        listo, wr, ejecutando, error_dir;
    logic [5:0]  direccion;
    logic [11:0] datoEntrante;
    logic [7:0]  palabras_cargadas;

    logic        reset2, valido2, ultimo2, recargar2;
    logic [5:0]  dir_in2;
    logic [11:0] dato_in2;
    logic        listo2, wr2, ejecutando2, error_dir2;
    logic [5:0]  direccion2;
    logic [11:0] datoEntrante2;
    logic [7:0]  palabras_cargadas2;

    logic [11:0] mem [64];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cargador_programa u_dut (
        .clk(clk), .reset(reset), .valido(valido), .listo(listo),
        .dir_in(dir_in), .dato_in(dato_in), .ultimo(ultimo), .recargar(recargar),
        .wr(wr), .direccion(direccion), .datoEntrante(datoEntrante),
        .ejecutando(ejecutando), .error_dir(error_dir), .palabras_cargadas(palabras_cargadas)
    );

    cargador_programa #(.PROFUNDIDAD(32)) u_dut32 (
        .clk(clk), .reset(reset2), .valido(valido2), .listo(listo2),
        .dir_in(dir_in2), .dato_in(dato_in2), .ultimo(ultimo2), .recargar(recargar2),
        .wr(wr2), .direccion(direccion2), .datoEntrante(datoEntrante2),
        .ejecutando(ejecutando2), .error_dir(error_dir2), .palabras_cargadas(palabras_cargadas2)
    );

    always @(posedge clk) begin
        if (wr) mem[direccion] <= datoEntrante;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts on the first cycle of a clear: direccion 0..63 two cycles each, then listo.
    task automatic limpiar_chk();
        for (int k = 0; k <= 128; k++) begin
            chk("limpiar", {wr, listo, ejecutando, datoEntrante, direccion},
                {1'b1, k == 128, 1'b0, 12'h000, 6'((k == 128) ? 63 : k / 2)});
            if (k < 128) @(negedge clk);
        end
    endtask

    task automatic enviar(input logic [5:0] d, input logic [11:0] w, input logic u);
        int n = 0;
        while (!listo && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("listo_espera", listo, 1);
        valido = 1'b1; dir_in = d; dato_in = w; ultimo = u;
        @(negedge clk);
        valido = 1'b0; ultimo = 1'b0;
        chk("escribir_c1", {wr, listo, direccion, datoEntrante}, {1'b1, 1'b0, d, w});
        @(negedge clk);
        chk("escribir_c2", {wr, listo, direccion, datoEntrante}, {1'b1, 1'b0, d, w});
        @(negedge clk);
        chk("tras_escribir", {wr, listo, ejecutando}, u ? 3'b001 : 3'b110);
    endtask

    task automatic recarga();
        recargar = 1'b1;
        @(negedge clk);
        recargar = 1'b0;
        chk("recarga_cont", {error_dir, palabras_cargadas}, 9'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz, idx, n;
        logic acc;
        for (int i = 0; i < 64; i++) mem[i] = 12'hAAA;
        reset = 1'b1; valido = 1'b0; ultimo = 1'b0; recargar = 1'b0;
        dir_in = '0; dato_in = '0;
        reset2 = 1'b1; valido2 = 1'b0; ultimo2 = 1'b0; recargar2 = 1'b0;
        dir_in2 = '0; dato_in2 = '0;

        repeat (6) @(negedge clk);
        chk("reset_estado", {wr, listo, ejecutando, error_dir, palabras_cargadas, direccion, datoEntrante},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 12'd0});
        reset = 1'b0;
        limpiar_chk();
        nz = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 12'h000) nz++;
        chk("mem_cero", nz, 0);

        recargar = 1'b1;
        @(negedge clk);
        recargar = 1'b0;
        chk("recargar_ignorado", {wr, listo, ejecutando}, 3'b110);

        enviar(6'd20, 12'h005, 1'b0);
        enviar(6'd21, 12'h00F, 1'b0);
        enviar(6'd0,  12'h114, 1'b0);
        enviar(6'd1,  12'h315, 1'b0);
        enviar(6'd2,  12'h216, 1'b1);
        chk("ejecutar", {wr, ejecutando, listo, direccion, datoEntrante}, {1'b0, 1'b1, 1'b0, 6'd0, 12'd0});
        chk("palabras5", palabras_cargadas, 8'd5);
        chk("mem20", mem[20], 12'h005);
        chk("mem21", mem[21], 12'h00F);
        chk("mem0", mem[0], 12'h114);
        chk("mem1", mem[1], 12'h315);
        chk("mem2", mem[2], 12'h216);

        recarga();
        limpiar_chk();
        nz = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 12'h000) nz++;
        chk("mem_cero2", nz, 0);

        valido = 1'b1; idx = 0;
        dir_in = 6'd10; dato_in = 12'h0A1; ultimo = 1'b0;
        for (int c = 0; c < 40 && idx < 3; c++) begin
            acc = listo;
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx == 1) begin dir_in = 6'd11; dato_in = 12'h0B2; ultimo = 1'b0; end
                if (idx == 2) begin dir_in = 6'd10; dato_in = 12'h0C3; ultimo = 1'b1; end
            end
        end
        n = 0;
        while (!ejecutando && n < 10) begin
            @(negedge clk);
            n++;
        end
        valido = 1'b0; ultimo = 1'b0;
        chk("stream_ejecutar", ejecutando, 1);
        chk("stream_palabras", palabras_cargadas, 8'd3);
        chk("stream_mem10", mem[10], 12'h0C3);
        chk("stream_mem11", mem[11], 12'h0B2);

        recarga();
        limpiar_chk();
        enviar(6'd0, 12'h114, 1'b1);
        chk("recarga_palabras", palabras_cargadas, 8'd1);
        chk("recarga_mem0", mem[0], 12'h114);
        chk("recarga_mem10", mem[10], 12'h000);

        recarga();
        repeat (128) @(negedge clk);
        valido = 1'b1; dir_in = 6'd30; dato_in = 12'h777; ultimo = 1'b0;
        @(negedge clk);
        valido = 1'b0;
        chk("pre_reset_escribir", {listo, direccion, palabras_cargadas}, {1'b0, 6'd30, 8'd1});
        #2 reset = 1'b1;
        #1 chk("reset_escribir", {wr, listo, ejecutando, palabras_cargadas, direccion, datoEntrante},
               {1'b1, 1'b0, 1'b0, 8'd0, 6'd0, 12'd0});
        @(negedge clk);
        reset = 1'b0;
        limpiar_chk();
        enviar(6'd3, 12'h0F0, 1'b1);
        chk("mem3", mem[3], 12'h0F0);
        #2 reset = 1'b1;
        #1 chk("reset_ejecutar", {wr, listo, ejecutando, palabras_cargadas, direccion, datoEntrante},
               {1'b1, 1'b0, 1'b0, 8'd0, 6'd0, 12'd0});
        @(negedge clk);
        reset = 1'b0;
        limpiar_chk();

        reset2 = 1'b0;
        for (int k = 0; k <= 64; k++) begin
            chk("limpiar32", {wr2, listo2, direccion2}, {1'b1, k == 64, 6'((k == 64) ? 31 : k / 2)});
            if (k < 64) @(negedge clk);
        end
        valido2 = 1'b1; dir_in2 = 6'd40; dato_in2 = 12'h00F; ultimo2 = 1'b0;
        @(negedge clk);
        valido2 = 1'b0;
        chk("fuera_rango", {error_dir2, listo2, wr2, direccion2, datoEntrante2, palabras_cargadas2},
            {1'b1, 1'b1, 1'b1, 6'd31, 12'd0, 8'd0});
        valido2 = 1'b1; dir_in2 = 6'd5; dato_in2 = 12'h123;
        @(negedge clk);
        valido2 = 1'b0;
        chk("tras_fuera", {error_dir2, listo2, direccion2, datoEntrante2, palabras_cargadas2},
            {1'b1, 1'b0, 6'd5, 12'h123, 8'd1});
        repeat (2) @(negedge clk);
        chk("listo32", listo2, 1);
        valido2 = 1'b1; dir_in2 = 6'd50; dato_in2 = 12'h001; ultimo2 = 1'b1;
        @(negedge clk);
        valido2 = 1'b0; ultimo2 = 1'b0;
        chk("fuera_ultimo", {ejecutando2, wr2, error_dir2, palabras_cargadas2}, {1'b1, 1'b0, 1'b1, 8'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cargador_programa.md
Name: cargador_programa

Overview:
- Upstream loader for the 12-bit accumulator processor: owns the processor's `wr`/`direccion`/`datoEntrante` inputs during program load.
- After reset it clears the whole memory to zero.
- It then accepts {address, word} records over a valid/ready handshake and writes each one into memory.
- On the record flagged `ultimo` it drops `wr` and releases the processor to execute.

Parameters:
- ANCHO_DATO, 12, instruction/data word width (4-bit opcode + 8-bit operand).
- ANCHO_DIR, 6, memory address width.
- PROFUNDIDAD, 64, number of memory words cleared; must be <= 2**ANCHO_DIR.
- CICLOS_ESCRITURA, 2, clock cycles each write is held stable on the memory port (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valido  in  1  upstream record valid.
- listo  out  1  loader ready to accept a record.
- dir_in  in  ANCHO_DIR  record target address.
- dato_in  in  ANCHO_DATO  record word.
- ultimo  in  1  record is the last of the program; qualified by valido&&listo.
- recargar  in  1  single-cycle request to reload; honoured only in EJECUTAR.
- wr  out  1  memory write enable to processor (1 = load mode, 0 = run).
- direccion  out  ANCHO_DIR  memory address to processor.
- datoEntrante  out  ANCHO_DATO  memory write data to processor.
- ejecutando  out  1  high while the processor is released.
- error_dir  out  1  sticky: a record addressed >= PROFUNDIDAD was dropped.
- palabras_cargadas  out  8  count of accepted records, saturating at 255.

Behaviour:

Reset state (asynchronous):
- state=LIMPIAR, wr=1, direccion=0, datoEntrante=0.
- listo=0, ejecutando=0, error_dir=0, palabras_cargadas=0.
- Hold counter=0.

LIMPIAR:
- wr=1, datoEntrante=0, listo=0.
- direccion steps 0..PROFUNDIDAD-1, each value held exactly CICLOS_ESCRITURA cycles.
- After the last address's hold, go to ESPERA. Total duration is PROFUNDIDAD*CICLOS_ESCRITURA cycles (128 at defaults).

ESPERA:
- wr=1, listo=1; direccion/datoEntrante keep their last values.
- A transfer occurs on a rising edge with valido&&listo. On that edge, latch dir_in/dato_in/ultimo onto direccion/datoEntrante and go to ESCRIBIR; listo=0 from the next cycle.
- Out-of-range record (dir_in >= PROFUNDIDAD): not written; error_dir set; state stays ESPERA. If ultimo is also set, go straight to EJECUTAR.
- palabras_cargadas increments on every accepted in-range record and saturates at 255.

ESCRIBIR:
- wr=1, listo=0; direccion/datoEntrante held for CICLOS_ESCRITURA cycles.
- Then go to EJECUTAR if the latched ultimo=1, else ESPERA.
- Accept-to-next-listo latency is CICLOS_ESCRITURA+1 cycles.

EJECUTAR:
- wr=0, ejecutando=1, listo=0, direccion=0, datoEntrante=0.
- A recargar pulse moves to LIMPIAR on the next edge and clears palabras_cargadas and error_dir.
- ejecutando falls and wr rises in the same cycle.

Boundary conditions:
- recargar outside EJECUTAR is ignored.
- valido while listo=0 is ignored; upstream must hold the record.
- A duplicate address is allowed; the last write wins.
- Reset in any state (mid-clear, mid-write, running) aborts immediately to the reset state; no partial hold completes.

Decomposition:
- Shared package (procesador_pkg) holds:
  - ANCHO_DATO, ANCHO_DIR, PROFUNDIDAD;
  - the opcode constants LOAD=1, STORE=2, ADD=3, SUB=4, MUL=5, DIV=6, AND=7, OR=8, XOR=9, NOT=10, JMP=11, INC=12, DEC=13, SHL=14, SHR=15;
  - the state enum {LIMPIAR, ESPERA, ESCRIBIR, EJECUTAR}.
- One natural sub-module, contador_retencion: a CICLOS_ESCRITURA hold counter with a `fin` pulse, reused by LIMPIAR and ESCRIBIR.

Test Plan:
1. Reset 6 cycles, release -> wr=1, direccion walks 0..63 with datoEntrante=0, each held 2 cycles; listo rises at cycle 128; processor memory is all zero.
2. Records (20,5), (21,15), (0,0x114), (1,0x315), (2,0x216 with ultimo) -> each held 2 cycles, listo re-asserts 3 cycles after accept. After the last record, wr=0, ejecutando=1, palabras_cargadas=5; processor accumulator reaches 5 then 20 and mem[22]=20.
3. valido held high continuously across ESCRIBIR -> exactly one write per listo window; no record lost or duplicated.
4. PROFUNDIDAD=32, record (40,15) -> no wr pulse at 40, error_dir=1 and stays set; the next valid record writes normally.
5. recargar pulse in EJECUTAR -> wr=1 next cycle, full 128-cycle clear restarts, counters cleared; a reload with a single ultimo record (0,0x114) runs.
6. Reset asserted mid-ESCRIBIR and again mid-EJECUTAR -> outputs take their reset values asynchronously, before the next clock edge; load sequence restarts from LIMPIAR.
